// File: rtl/flash_spi_monitor.sv
// Passive SPI flash bus monitor: oversamples buffered CSB/SCLK/IO0/IO1 in the
// wb_clk domain and decodes command, address and read-data bytes.
module flash_spi_monitor #(
  parameter int ADDR_BYTES = 3,
  parameter int CNT_W      = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    flash_csb_i,
  input  logic                    flash_clk_i,
  input  logic                    flash_io0_i,
  input  logic                    flash_io1_i,
  input  logic                    clear_i,
  output logic [7:0]              cmd_o,
  output logic                    cmd_valid_o,
  output logic [8*ADDR_BYTES-1:0] addr_o,
  output logic                    addr_valid_o,
  output logic [7:0]              rdata_o,
  output logic                    rdata_valid_o,
  output logic [CNT_W-1:0]        byte_cnt_o,
  output logic [CNT_W-1:0]        xfer_cnt_o,
  output logic                    frag_err_o,
  output logic                    busy_o
);

  localparam int              AW         = 8 * ADDR_BYTES;
  localparam logic [1:0]      LAST_ABYTE = 2'(ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  // Synchronizer bit order: {io1, io0, sclk, csb}
  logic [3:0]    r_s1, r_s2, r_s3;
  logic [1:0]    r_warm;
  logic          r_armed;
  logic          r_ev_sclk, r_ev_fall, r_ev_rise, r_ev_io0, r_ev_io1;
  state_t        r_state, w_state_nxt;
  logic [2:0]    r_bit_cnt;
  logic [1:0]    r_abyte;
  logic [7:0]    r_sh_mosi, r_sh_miso;
  logic [AW-1:0] r_sh_addr;
  logic [7:0]    r_cmd, r_rdata;
  logic [AW-1:0] r_addr;
  logic          r_cmd_valid, r_addr_valid, r_rdata_valid;
  logic [CNT_W-1:0] r_byte_cnt, r_xfer_cnt;
  logic          r_frag_err, r_busy;

  logic          w_sclk_rise, w_csb_fall, w_csb_rise;
  logic          w_byte_done;
  logic [7:0]    w_mosi_byte, w_miso_byte;
  logic [AW-1:0] w_addr_word;
  logic          w_bits_clr, w_shift, w_cmd_load, w_addr_load, w_data_load;
  logic          w_abyte_inc, w_xfer_inc, w_frag_set;

  assign w_sclk_rise = r_s2[1] & ~r_s3[1];
  assign w_csb_fall  = ~r_s2[0] & r_s3[0];
  assign w_csb_rise  = r_s2[0] & ~r_s3[0];
  assign w_byte_done = (r_bit_cnt == 3'd7);
  assign w_mosi_byte = {r_sh_mosi[6:0], r_ev_io0};
  assign w_miso_byte = {r_sh_miso[6:0], r_ev_io1};
  assign w_addr_word = {r_sh_addr[AW-2:0], r_ev_io0};

  // Input synchronizers, edge history and a registered event stage.
  // r_warm keeps the reset value of s2 from arming the decoder.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_s1      <= 4'b0001;
      r_s2      <= 4'b0001;
      r_s3      <= 4'b0001;
      r_warm    <= 2'd0;
      r_armed   <= 1'b0;
      r_ev_sclk <= 1'b0;
      r_ev_fall <= 1'b0;
      r_ev_rise <= 1'b0;
      r_ev_io0  <= 1'b0;
      r_ev_io1  <= 1'b0;
    end else begin
      r_s1      <= {flash_io1_i, flash_io0_i, flash_clk_i, flash_csb_i};
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      r_warm    <= (r_warm == 2'd2) ? r_warm : r_warm + 2'd1;
      r_armed   <= r_armed | ((r_warm == 2'd2) & r_s2[0]);
      r_ev_sclk <= w_sclk_rise;
      r_ev_fall <= w_csb_fall;
      r_ev_rise <= w_csb_rise;
      r_ev_io0  <= r_s2[2];
      r_ev_io1  <= r_s2[3];
    end
  end

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control; CSB rise outranks a same-cycle SCLK rise
  always_comb begin
    w_state_nxt = r_state;
    w_bits_clr  = 1'b0;
    w_shift     = 1'b0;
    w_cmd_load  = 1'b0;
    w_addr_load = 1'b0;
    w_data_load = 1'b0;
    w_abyte_inc = 1'b0;
    w_xfer_inc  = 1'b0;
    w_frag_set  = 1'b0;
    if (r_state == ST_IDLE) begin
      if (r_ev_fall && r_armed) begin
        w_state_nxt = ST_CMD;
        w_bits_clr  = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else if (r_ev_rise) begin
      w_state_nxt = ST_IDLE;
      w_xfer_inc  = 1'b1;
      w_frag_set  = (r_bit_cnt != 3'd0);
    end else if (r_ev_fall) begin
      w_state_nxt = ST_CMD;
      w_bits_clr  = 1'b1;
    end else if (r_ev_sclk) begin
      w_shift = 1'b1;
      if (w_byte_done) begin
        case (r_state)
          ST_CMD: begin
            w_cmd_load  = 1'b1;
            w_state_nxt = ((w_mosi_byte == 8'h03) || (w_mosi_byte == 8'h0B)) ? ST_ADDR : ST_DATA;
          end
          ST_ADDR: begin
            if (r_abyte == LAST_ABYTE) begin
              w_addr_load = 1'b1;
              w_state_nxt = ST_DATA;
            end else begin
              w_abyte_inc = 1'b1;
            end
          end
          ST_DATA: w_data_load = 1'b1;
          default: w_state_nxt = ST_IDLE;
        endcase
      end else begin
        w_state_nxt = r_state;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Bit/byte counters and MSB-first shifters
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_bit_cnt <= 3'd0;
      r_abyte   <= 2'd0;
      r_sh_mosi <= 8'h00;
      r_sh_miso <= 8'h00;
      r_sh_addr <= {AW{1'b0}};
    end else begin
      if (w_bits_clr) begin
        r_bit_cnt <= 3'd0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end
      if (w_bits_clr) begin
        r_abyte <= 2'd0;
      end else if (w_abyte_inc) begin
        r_abyte <= r_abyte + 2'd1;
      end else begin
        r_abyte <= r_abyte;
      end
      if (w_shift) begin
        r_sh_mosi <= w_mosi_byte;
        r_sh_miso <= w_miso_byte;
        r_sh_addr <= w_addr_word;
      end
    end
  end

  // Published fields and one-cycle pulses
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cmd         <= 8'h00;
      r_addr        <= {AW{1'b0}};
      r_rdata       <= 8'h00;
      r_cmd_valid   <= 1'b0;
      r_addr_valid  <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_cmd_valid   <= w_cmd_load;
      r_addr_valid  <= w_addr_load;
      r_rdata_valid <= w_data_load;
      r_busy        <= (w_state_nxt != ST_IDLE);
      if (w_cmd_load)  r_cmd   <= w_mosi_byte;
      if (w_addr_load) r_addr  <= w_addr_word;
      if (w_data_load) r_rdata <= w_miso_byte;
    end
  end

  // Saturating counters and sticky error; clear_i beats a same-cycle update
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clear_i) begin
      r_byte_cnt <= {CNT_W{1'b0}};
      r_xfer_cnt <= {CNT_W{1'b0}};
      r_frag_err <= 1'b0;
    end else begin
      if (w_data_load && (r_byte_cnt != CNT_MAX)) r_byte_cnt <= r_byte_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_xfer_inc && (r_xfer_cnt != CNT_MAX))  r_xfer_cnt <= r_xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_frag_set) r_frag_err <= 1'b1;
    end
  end

  assign cmd_o         = r_cmd;
  assign cmd_valid_o   = r_cmd_valid;
  assign addr_o        = r_addr;
  assign addr_valid_o  = r_addr_valid;
  assign rdata_o       = r_rdata;
  assign rdata_valid_o = r_rdata_valid;
  assign byte_cnt_o    = r_byte_cnt;
  assign xfer_cnt_o    = r_xfer_cnt;
  assign frag_err_o    = r_frag_err;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_flash_spi_monitor.sv
// Scoreboard bench for flash_spi_monitor: stimulus queues expected pulses,
// a monitor pops and compares whenever a valid pulse appears.
module tb_flash_spi_monitor;
  localparam int AB = 3;
  localparam int CW = 4;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i, csb, sclk, io0, io1, clr;
  logic [7:0]    cmd_o, rdata_o;
  logic [8*AB-1:0] addr_o;
  logic          cmd_valid_o, addr_valid_o, rdata_valid_o, frag_err_o, busy_o;
  logic [CW-1:0] byte_cnt_o, xfer_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_cmd_cyc = -1;
  logic [7:0]  q_cmd[$];
  logic [23:0] q_addr[$];
  logic [7:0]  q_rd[$];
  logic [7:0]  m_e8;
  logic [23:0] m_e24;
  logic [7:0]  lat_cmd;

  flash_spi_monitor #(.ADDR_BYTES(AB), .CNT_W(CW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .flash_csb_i(csb), .flash_clk_i(sclk),
    .flash_io0_i(io0), .flash_io1_i(io1), .clear_i(clr),
    .cmd_o(cmd_o), .cmd_valid_o(cmd_valid_o), .addr_o(addr_o), .addr_valid_o(addr_valid_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .byte_cnt_o(byte_cnt_o),
    .xfer_cnt_o(xfer_cnt_o), .frag_err_o(frag_err_o), .busy_o(busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sbit(input logic b0, input logic b1);
    io0 = b0; io1 = b1;
    tick(4); sclk = 1'b1;
    tick(4); sclk = 1'b0;
  endtask

  task automatic sbyte(input logic [7:0] m, input logic [7:0] s);
    for (int i = 7; i >= 0; i--) sbit(m[i], s[i]);
  endtask

  task automatic cs_lo();
    csb = 1'b0; tick(4);
  endtask

  task automatic cs_hi();
    tick(4); csb = 1'b1; tick(8);
  endtask

  task automatic pulse_clear();
    clr = 1'b1; tick(1); clr = 1'b0; tick(1);
  endtask

  // Scoreboard monitor
  always @(posedge wb_clk_i) begin
    #1;
    if (cmd_valid_o === 1'b1) begin
      n_tests++;
      if (q_cmd.size() == 0) begin
        n_fail++; $display("FAIL cmd_unexpected: got %02h expected none", cmd_o);
      end else begin
        m_e8 = q_cmd.pop_front();
        if (cmd_o !== m_e8) begin n_fail++; $display("FAIL cmd: got %02h expected %02h", cmd_o, m_e8); end
      end
      if (exp_cmd_cyc >= 0) begin
        n_tests++;
        if (cyc != exp_cmd_cyc) begin n_fail++; $display("FAIL cmd_latency: got cycle %0d expected %0d", cyc, exp_cmd_cyc); end
        exp_cmd_cyc = -1;
      end
    end
    if (addr_valid_o === 1'b1) begin
      n_tests++;
      if (q_addr.size() == 0) begin
        n_fail++; $display("FAIL addr_unexpected: got %06h expected none", addr_o);
      end else begin
        m_e24 = q_addr.pop_front();
        if (addr_o !== m_e24) begin n_fail++; $display("FAIL addr: got %06h expected %06h", addr_o, m_e24); end
      end
    end
    if (rdata_valid_o === 1'b1) begin
      n_tests++;
      if (q_rd.size() == 0) begin
        n_fail++; $display("FAIL rdata_unexpected: got %02h expected none", rdata_o);
      end else begin
        m_e8 = q_rd.pop_front();
        if (rdata_o !== m_e8) begin n_fail++; $display("FAIL rdata: got %02h expected %02h", rdata_o, m_e8); end
      end
    end
  end

  initial begin
    csb = 1'b0; sclk = 1'b0; io0 = 1'b0; io1 = 1'b0; clr = 1'b0; wb_rst_i = 1'b1;
    tick(3); wb_rst_i = 1'b0; tick(2);
    chk("rst_cmd", 32'(cmd_o), 32'h0);
    chk("rst_addr", 32'(addr_o), 32'h0);
    chk("rst_rdata", 32'(rdata_o), 32'h0);
    chk("rst_bytecnt", 32'(byte_cnt_o), 32'h0);
    chk("rst_xfer", 32'(xfer_cnt_o), 32'h0);
    chk("rst_frag", 32'(frag_err_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);

    // CSB already low at reset: no decode
    sbyte(8'h9F, 8'h00);
    chk("unarmed_busy", 32'(busy_o), 32'h0);
    cs_hi();
    chk("unarmed_xfer", 32'(xfer_cnt_o), 32'h0);
    chk("unarmed_cmd", 32'(cmd_o), 32'h0);

    // Read 0x03 @ 0x123456, two data bytes
    q_cmd.push_back(8'h03); q_addr.push_back(24'h123456);
    q_rd.push_back(8'hA5); q_rd.push_back(8'h5A);
    cs_lo();
    chk("busy_active", 32'(busy_o), 32'h1);
    sbyte(8'h03, 8'h00); sbyte(8'h12, 8'h00); sbyte(8'h34, 8'h00); sbyte(8'h56, 8'h00);
    sbyte(8'h00, 8'hA5); sbyte(8'h00, 8'h5A);
    cs_hi();
    chk("read_addr", 32'(addr_o), 32'h123456);
    chk("read_bytecnt", 32'(byte_cnt_o), 32'h2);
    chk("read_xfer", 32'(xfer_cnt_o), 32'h1);
    chk("read_frag", 32'(frag_err_o), 32'h0);
    chk("read_busy", 32'(busy_o), 32'h0);

    // JEDEC ID 0x9F: no address phase
    q_cmd.push_back(8'h9F);
    q_rd.push_back(8'hEF); q_rd.push_back(8'h40); q_rd.push_back(8'h18);
    cs_lo();
    sbyte(8'h9F, 8'h00); sbyte(8'h00, 8'hEF); sbyte(8'h00, 8'h40); sbyte(8'h00, 8'h18);
    cs_hi();
    chk("id_bytecnt", 32'(byte_cnt_o), 32'h5);
    chk("id_xfer", 32'(xfer_cnt_o), 32'h2);
    chk("id_addr_held", 32'(addr_o), 32'h123456);
    chk("id_rdata", 32'(rdata_o), 32'h18);

    // Fragment: 5 command bits then CSB high
    pulse_clear();
    chk("clr1_xfer", 32'(xfer_cnt_o), 32'h0);
    cs_lo();
    for (int i = 0; i < 5; i++) sbit(1'b1, 1'b0);
    cs_hi();
    chk("frag_err", 32'(frag_err_o), 32'h1);
    chk("frag_xfer", 32'(xfer_cnt_o), 32'h1);
    chk("frag_bytecnt", 32'(byte_cnt_o), 32'h0);
    pulse_clear();
    chk("clr2_frag", 32'(frag_err_o), 32'h0);
    chk("clr2_xfer", 32'(xfer_cnt_o), 32'h0);
    chk("clr2_bytecnt", 32'(byte_cnt_o), 32'h0);

    // Latency: 8th SCLK rise, CSB rise one wb_clk later
    lat_cmd = 8'hAB;
    q_cmd.push_back(lat_cmd);
    cs_lo();
    for (int i = 7; i >= 1; i--) sbit(lat_cmd[i], 1'b0);
    io0 = lat_cmd[0];
    tick(4); sclk = 1'b1; exp_cmd_cyc = cyc + 4;
    tick(1); csb = 1'b1;
    tick(3); sclk = 1'b0; tick(8);
    chk("lat_frag", 32'(frag_err_o), 32'h0);
    chk("lat_xfer", 32'(xfer_cnt_o), 32'h1);
    chk("lat_seen", 32'(exp_cmd_cyc), 32'hFFFF_FFFF);

    // CSB rise coinciding with the 8th SCLK rise: edge dropped
    cs_lo();
    for (int i = 7; i >= 1; i--) sbit(lat_cmd[i], 1'b0);
    io0 = lat_cmd[0];
    tick(4); sclk = 1'b1; csb = 1'b1;
    tick(4); sclk = 1'b0; tick(8);
    chk("coinc_frag", 32'(frag_err_o), 32'h1);
    chk("coinc_xfer", 32'(xfer_cnt_o), 32'h2);
    chk("coinc_cmd", 32'(cmd_o), 32'hAB);

    // Saturation of a 4-bit transfer counter
    pulse_clear();
    for (int t = 0; t < 17; t++) begin
      q_cmd.push_back(8'h06);
      cs_lo(); sbyte(8'h06, 8'h00); cs_hi();
      if (t == 13) chk("sat_14", 32'(xfer_cnt_o), 32'hE);
      if (t == 14) chk("sat_15", 32'(xfer_cnt_o), 32'hF);
    end
    chk("sat_17", 32'(xfer_cnt_o), 32'hF);
    chk("sat_bytecnt", 32'(byte_cnt_o), 32'h0);

    // Reset mid-transfer
    cs_lo();
    for (int i = 0; i < 4; i++) sbit(1'b1, 1'b1);
    chk("pre_rst_busy", 32'(busy_o), 32'h1);
    wb_rst_i = 1'b1; tick(1);
    chk("mid_rst_cmd", 32'(cmd_o), 32'h0);
    chk("mid_rst_addr", 32'(addr_o), 32'h0);
    chk("mid_rst_rdata", 32'(rdata_o), 32'h0);
    chk("mid_rst_xfer", 32'(xfer_cnt_o), 32'h0);
    chk("mid_rst_frag", 32'(frag_err_o), 32'h0);
    chk("mid_rst_busy", 32'(busy_o), 32'h0);
    wb_rst_i = 1'b0; csb = 1'b1; tick(8);

    chk("q_cmd_empty", 32'(q_cmd.size()), 32'h0);
    chk("q_addr_empty", 32'(q_addr.size()), 32'h0);
    chk("q_rd_empty", 32'(q_rd.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/flash_spi_monitor.md
Name: flash_spi_monitor

Overview:
- Passive observer on the buffered flash SPI lines (CSB, SCLK, IO0, IO1) after the flash clock/reset buffer stage.
- Oversamples those lines in the Wishbone clock domain and decodes each transaction: command byte, address, read-data bytes.
- Publishes decoded fields, transfer/byte counters and a fragment-error flag to user logic.
- Never drives the flash bus.

Parameters:
- ADDR_BYTES, 3, number of address bytes following a read command (1..4).
- CNT_W, 16, width of the byte and transfer counters.

Ports:
- wb_clk_i  input  1  system clock; must be at least 4x the SCLK frequency.
- wb_rst_i  input  1  reset, synchronous, active-high.
- flash_csb_i  input  1  buffered flash chip select, active-low.
- flash_clk_i  input  1  buffered flash SCLK, SPI mode 0.
- flash_io0_i  input  1  buffered MOSI.
- flash_io1_i  input  1  buffered MISO.
- clear_i  input  1  one-cycle pulse; clears counters and error.
- cmd_o  output  8  last captured command byte.
- cmd_valid_o  output  1  one-cycle pulse when cmd_o updates.
- addr_o  output  8*ADDR_BYTES  last captured address, MSB first on the wire.
- addr_valid_o  output  1  one-cycle pulse when addr_o updates.
- rdata_o  output  8  last MISO data byte.
- rdata_valid_o  output  1  one-cycle pulse when rdata_o updates.
- byte_cnt_o  output  CNT_W  completed data-phase bytes; saturating.
- xfer_cnt_o  output  CNT_W  completed transactions; saturating.
- frag_err_o  output  1  sticky: CSB rose with a partial byte.
- busy_o  output  1  high while a transaction is active.

Behaviour:
- Reset: one clock, synchronous, active-high; reset is wb_rst_i.
- All outputs reset to 0. Synchronizer flops reset to CSB=1, all others 0. FSM resets to IDLE with armed=0.
- Sampling:
  - Each input passes through two flops (s1, s2); a third flop (s3) holds the previous s2 for edge detection.
  - sclk_rise = s2 & ~s3; csb_fall and csb_rise are derived the same way.
  - Data bits are taken from s2 of IO0/IO1 on sclk_rise.
- Latency: all outputs are registered. A pulse asserts 3 wb_clk edges after the edge that first samples the triggering SCLK or CSB transition.
- Shift logic: 3-bit bit counter; shift registers are MSB first. A byte completes on the 8th sclk_rise.
- FSM states and transitions:
  - IDLE: on csb_fall with armed=1, go to CMD; clear bit counter; busy_o=1.
  - CMD: on byte complete, load cmd_o and pulse cmd_valid_o. Go to ADDR if the byte is 0x03 or 0x0B, otherwise to DATA.
  - ADDR: shift IO0 for ADDR_BYTES*8 edges, using a byte counter. Then load addr_o, pulse addr_valid_o, go to DATA.
  - DATA: each complete byte loads rdata_o from the IO1 shifter, pulses rdata_valid_o and increments byte_cnt_o. Dummy bytes of 0x0B are counted as data.
- Transaction end: csb_rise in any non-IDLE state takes priority over a same-cycle sclk_rise, which is ignored. On csb_rise:
  - go to IDLE; busy_o=0; xfer_cnt_o increments;
  - if the bit counter is nonzero, set frag_err_o; no partial-byte pulse is issued.
- armed rule:
  - armed is set whenever synced CSB=1.
  - After reset with CSB already low, the block stays IDLE until CSB goes high and then low again.
- Unexpected csb_fall while not in IDLE (missed rise): restart in CMD; xfer_cnt_o is not incremented.
- Counters saturate at all-ones.
- clear_i:
  - zeroes byte_cnt_o, xfer_cnt_o and frag_err_o.
  - If a clear and an increment occur in the same cycle, clear wins (result 0).
  - FSM state and data registers are not affected.
- SCLK edges while CSB is high are ignored.

Test Plan:
- Reset with CSB low, then a CSB low pulse -> no decode until CSB goes high then low again. All outputs 0 before that.
- Command 0x03 with address 0x12_34_56, then 2 MISO bytes 0xA5 and 0x5A, then CSB high:
  - cmd_o=0x03, addr_o=0x123456, rdata pulses with 0xA5 then 0x5A;
  - byte_cnt_o=2, xfer_cnt_o=1, frag_err_o=0.
- Command 0x9F followed by 3 bytes 0xEF, 0x40, 0x18 -> no addr_valid_o pulse; rdata sequence EF, 40, 18; byte_cnt_o=3.
- CSB rises after 5 bits of the command -> no cmd_valid_o; frag_err_o=1; xfer_cnt_o=1.
  - Then pulse clear_i -> all three cleared.
- Check latency: the 8th sclk_rise, with CSB rise injected one wb_clk later, yields cmd_valid_o exactly 3 edges after sampling.
  - Also: CSB rise coinciding with an edge -> edge ignored, frag_err_o set.
- With CNT_W=4, run 17 single-byte 0x06 transactions -> xfer_cnt_o saturates at 0xF.
  - Assert wb_rst_i mid-transfer -> all outputs 0 next cycle.
